// File: rtl/mdu_sequencer.sv
// -----------------------------------------------------------------------------
// mdu_sequencer
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// MULT/MULTU run as a shift-add sequence and DIV/DIVU as a restoring divide.
// Each operation takes one iteration per operand bit, with a PREP cycle
// before the iterations and a FIX cycle after them. MTHI/MTLO writes are
// serviced while the unit is idle.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   start      : launch an operation (sampled only while idle)
//   op[1:0]    : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b       : multiplicand/dividend and multiplier/divisor, captured with start
//   flush      : abort the operation in flight; blocks a start while idle
//   hi_we      : MTHI write strobe (idle only)
//   lo_we      : MTLO write strobe (idle only)
//   wdata      : MTHI/MTLO data
//   busy       : operation in PREP, ITER or FIX
//   done       : one-cycle pulse in the cycle HI/LO show a new result
//   div_zero   : pulses with done when a divide had a zero divisor
//   hi, lo     : HI and LO registers
// -----------------------------------------------------------------------------
module mdu_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int W2  = 2 * WIDTH;
   localparam int MSB = WIDTH - 1;
   localparam int CW  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PREP = 2'd1,
      ST_ITER = 2'd2,
      ST_FIX  = 2'd3
   } state_t;

   state_t            state_r;
   state_t            state_s;

   // captured request
   logic [1:0]        op_r;
   logic [WIDTH-1:0]  a_r;
   logic [WIDTH-1:0]  b_r;

   // iteration datapath: mag_r is the multiplicand or the divisor magnitude;
   // acc_r holds {partial product, multiplier} or {remainder, dividend/quotient}
   logic [WIDTH-1:0]  mag_r;
   logic [W2-1:0]     acc_r;
   logic [CW-1:0]     cnt_r;
   logic              psign_r;
   logic              rsign_r;
   logic              dz_r;

   // architectural and status registers
   logic [WIDTH-1:0]  hi_r;
   logic [WIDTH-1:0]  lo_r;
   logic              busy_r;
   logic              done_r;
   logic              div_zero_r;

   // control strobes
   logic              capture_s;
   logic              prep_s;
   logic              iter_s;
   logic              fix_s;
   logic              mt_en_s;
   logic              busy_s;
   logic              done_s;
   logic              div_zero_s;

   // datapath combinational values
   logic [WIDTH:0]    mul_sum_s;
   logic [WIDTH:0]    div_trial_s;
   logic [W2-1:0]     acc_step_s;
   logic [W2-1:0]     prod_s;
   logic [WIDTH-1:0]  res_hi_s;
   logic [WIDTH-1:0]  res_lo_s;

   // Two's-complement negate of a WIDTH-bit value when neg is set.
   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
      logic [WIDTH-1:0] one;
      one = {{(WIDTH-1){1'b0}}, 1'b1};
      if (neg) begin
         return (~x) + one;
      end else begin
         return x;
      end
   endfunction

   // Two's-complement negate of a 2*WIDTH-bit value when neg is set.
   function automatic logic [W2-1:0] cond_neg_wide(input logic [W2-1:0] x, input logic neg);
      logic [W2-1:0] one;
      one = {{(W2-1){1'b0}}, 1'b1};
      if (neg) begin
         return (~x) + one;
      end else begin
         return x;
      end
   endfunction

   // Magnitude of an operand: only signed ops with the MSB set are negated.
   // The most negative value maps onto itself, read as unsigned it is correct.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic is_signed);
      return cond_neg(x, is_signed & x[MSB]);
   endfunction

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; flush returns to IDLE from any busy state.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start && !flush) begin
               state_s = ST_PREP;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_PREP: begin
            if (flush) begin
               state_s = ST_IDLE;
            end else if (op_r[1] && (b_r == {WIDTH{1'b0}})) begin
               state_s = ST_FIX;
            end else begin
               state_s = ST_ITER;
            end
         end
         ST_ITER: begin
            if (flush) begin
               state_s = ST_IDLE;
            end else if (cnt_r == CNT_LAST) begin
               state_s = ST_FIX;
            end else begin
               state_s = ST_ITER;
            end
         end
         ST_FIX: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Output/control decode; busy, done and div_zero are registered from these.
   always_comb begin
      capture_s  = 1'b0;
      prep_s     = 1'b0;
      iter_s     = 1'b0;
      fix_s      = 1'b0;
      mt_en_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            capture_s = start & ~flush;
            mt_en_s   = 1'b1;
         end
         ST_PREP: begin
            prep_s = ~flush;
         end
         ST_ITER: begin
            iter_s = ~flush;
         end
         ST_FIX: begin
            fix_s = ~flush;
         end
         default: begin
            mt_en_s = 1'b0;
         end
      endcase
      busy_s     = (state_s != ST_IDLE);
      done_s     = fix_s;
      div_zero_s = fix_s & dz_r;
   end

   // One iteration step: shift-add for multiply, restoring step for divide.
   always_comb begin
      mul_sum_s   = {1'b0, acc_r[W2-1:WIDTH]}
                  + (acc_r[0] ? {1'b0, mag_r} : {(WIDTH+1){1'b0}});
      // remainder shifted left by one with the next dividend bit, minus divisor
      div_trial_s = acc_r[W2-1:WIDTH-1] - {1'b0, mag_r};
      if (op_r[1]) begin
         if (div_trial_s[WIDTH]) begin
            // trial went negative: keep the shifted remainder, quotient bit 0
            acc_step_s = {acc_r[W2-2:0], 1'b0};
         end else begin
            acc_step_s = {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
         end
      end else begin
         acc_step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
      end
   end

   // Final sign fix-up and HI/LO result selection.
   always_comb begin
      prod_s = cond_neg_wide(acc_r, psign_r);
      if (dz_r) begin
         res_hi_s = a_r;
         res_lo_s = {WIDTH{1'b1}};
      end else if (op_r[1]) begin
         res_hi_s = cond_neg(acc_r[W2-1:WIDTH], rsign_r);
         res_lo_s = cond_neg(acc_r[WIDTH-1:0], psign_r);
      end else begin
         res_hi_s = prod_s[W2-1:WIDTH];
         res_lo_s = prod_s[WIDTH-1:0];
      end
   end

   // Request capture, operand preparation and iteration datapath.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r    <= 2'b00;
         a_r     <= {WIDTH{1'b0}};
         b_r     <= {WIDTH{1'b0}};
         mag_r   <= {WIDTH{1'b0}};
         acc_r   <= {W2{1'b0}};
         cnt_r   <= {CW{1'b0}};
         psign_r <= 1'b0;
         rsign_r <= 1'b0;
         dz_r    <= 1'b0;
      end else if (capture_s) begin
         op_r <= op;
         a_r  <= a;
         b_r  <= b;
      end else if (prep_s) begin
         // op_r[0] set means unsigned: magnitudes pass through, signs are 0
         mag_r   <= op_r[1] ? magnitude(b_r, ~op_r[0]) : magnitude(a_r, ~op_r[0]);
         acc_r   <= {{WIDTH{1'b0}},
                     (op_r[1] ? magnitude(a_r, ~op_r[0]) : magnitude(b_r, ~op_r[0]))};
         psign_r <= ~op_r[0] & (a_r[MSB] ^ b_r[MSB]);
         rsign_r <= ~op_r[0] & a_r[MSB];
         dz_r    <= op_r[1] & (b_r == {WIDTH{1'b0}});
         cnt_r   <= {CW{1'b0}};
      end else if (iter_s) begin
         acc_r <= acc_step_s;
         cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
   end

   // HI/LO: result write in FIX, otherwise MTHI/MTLO while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_r <= {WIDTH{1'b0}};
         lo_r <= {WIDTH{1'b0}};
      end else if (fix_s) begin
         hi_r <= res_hi_s;
         lo_r <= res_lo_s;
      end else if (mt_en_s) begin
         if (hi_we) begin
            hi_r <= wdata;
         end
         if (lo_we) begin
            lo_r <= wdata;
         end
      end
   end

   // Registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         div_zero_r <= 1'b0;
      end else begin
         busy_r     <= busy_s;
         done_r     <= done_s;
         div_zero_r <= div_zero_s;
      end
   end

   assign busy     = busy_r;
   assign done     = done_r;
   assign div_zero = div_zero_r;
   assign hi       = hi_r;
   assign lo       = lo_r;

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Iterative multiply/divide unit with HI/LO registers for the pipelined CPU. It runs MULT/MULTU/DIV/DIVU as a multi-cycle shift-add or restoring-divide sequence, separate from the single-cycle ALU. It reports `busy` to the hazard logic so that the pipeline stalls HI/LO consumers. It also services MTHI/MTLO writes.

## Interface
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a new operation; sampled only in IDLE.
- `op` in 2: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `a` in `WIDTH`: multiplicand or dividend; captured with `start`.
- `b` in `WIDTH`: multiplier or divisor; captured with `start`.
- `flush` in 1: abort the operation in flight; synchronous.
- `hi_we` in 1: write `wdata` into HI; honoured only in IDLE.
- `lo_we` in 1: write `wdata` into LO; honoured only in IDLE.
- `wdata` in `WIDTH`: MTHI/MTLO data.
- `busy` out 1: high in PREP, ITER and FIX.
- `done` out 1: one-cycle pulse when HI/LO take a result.
- `div_zero` out 1: pulses with `done` when a divide had `b == 0`.
- `hi` out `WIDTH`: HI register.
- `lo` out `WIDTH`: LO register.

## Operation
- States and transitions:
  - IDLE -> PREP on `start & ~flush`.
  - PREP -> ITER, or PREP -> FIX for a divide with `b == 0`.
  - ITER -> FIX after `WIDTH` iterations.
  - FIX -> IDLE.
- PREP:
  - Signed ops: latch the magnitudes |a| and |b|.
  - Record the result sign: `a[MSB]^b[MSB]` for the product and quotient; `a[MSB]` for the remainder.
  - Unsigned ops: pass operands through unchanged; signs are 0.
  - Clear the iteration counter.
- ITER, multiply: one shift-add step per cycle into a 2·`WIDTH` accumulator, LSB-first on the multiplier.
- ITER, divide: one restoring step per cycle (shift the remainder, trial-subtract the divisor, set the quotient bit). The counter increments every cycle.
- FIX, multiply: negate the 2·`WIDTH` product if its sign is set; HI = upper half, LO = lower half.
- FIX, divide: LO = quotient, HI = remainder, each negated per its sign. Quotient truncates toward zero.
- Divide by zero, signed or unsigned: HI = `a` as captured, LO = all ones, `div_zero` = 1 with `done`.
- Signed overflow 0x80000000 / 0xFFFFFFFF falls out naturally: LO = 0x80000000, HI = 0. No flag.
- `start` while busy is ignored; the operation in progress is unaffected.
- `flush` in any non-IDLE state: next edge -> IDLE. HI/LO are unchanged and no `done`.
- `flush` with `start` in IDLE: flush wins and the operation is not started.
- `hi_we`/`lo_we` in IDLE update HI/LO on the same edge, including a cycle where `start` is also high. The started op later overwrites both registers.
- `hi_we`/`lo_we` while busy are ignored.
- `hi`/`lo` change only on a FIX edge, an MTHI/MTLO write, or reset.

## Timing
- Reset (async assert, any state): state = IDLE, counter = 0, `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, `div_zero` = 0.
- Reset mid-operation discards the operation.
- Normal op, edge numbering:
  - E0 samples `start`: `busy` = 1.
  - E1: PREP -> ITER.
  - E2..E(WIDTH+1): the `WIDTH` iterations.
  - E(WIDTH+2): FIX writes HI/LO, asserts `done`, `busy` = 0.
  - Latency is therefore `WIDTH`+2 edges after the start edge, i.e. 34 edges for `WIDTH` = 32.
- Divide by zero: E1 PREP -> FIX; E2 writes HI/LO and pulses `done` and `div_zero`.
- `done` and `div_zero` are registered and high for exactly one cycle. `hi`/`lo` are valid in the same cycle as `done`.
- A new `start` is accepted in the cycle `done` is high, since the state is already IDLE. Back-to-back ops therefore have no gap cycle.
- MTHI/MTLO: the write is visible on `hi`/`lo` the cycle after the edge.

## Test plan
- MULT a=0xFFFFFFFD (-3), b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Check: `done` exactly 34 edges after the start edge, and `busy` high for 34 cycles.
- MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Then DIV a=0xFFFFFFF9 (-7), b=2 issued in the `done` cycle -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=100, b=0 -> HI=0x64, LO=0xFFFFFFFF, `div_zero`=`done`=1 at edge E2.
- Signed overflow: DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0, `div_zero`=0.
- MTHI 0x1234 in IDLE, then start MULT 5×6, then `flush` at edge E10 -> `busy` low next cycle, no `done`, `hi`=0x1234, `lo` unchanged. Also check that a `start` during busy is ignored.
- Assert `rst_n`=0 mid-ITER (asynchronously, between edges) -> all outputs 0 immediately, no `done` after release. Then a fresh DIVU 9/4 -> LO=2, HI=1.
